ifm_chunk_ring_buffer: RTL and testbench

//  N-bank ring buffer of sparse-compressed IFM chunks. It is the parametrised successor of the two-bank ping-pong chunk store.
//  - Write side: streams BUS-wide sparsemap/nonzero beats under valid/ready. Each bank holds one chunk.
//  - Read side: presents the oldest complete chunk to COMPUTE_UNIT_NUM units until they release it.
//  - Zero-padded read: address 0 and out-of-range addresses return 8'h00.
//  - Sits between the IFM DMA and the compute-unit array.

---
 rtl/ifm_chunk_ring_buffer_pkg.sv | 29 ++
 rtl/ifm_chunk_ring_buffer_if.sv | 14 +
 rtl/ifm_chunk_ring_buffer_bank.sv | 54 +++++
 rtl/ifm_chunk_ring_buffer.sv | 128 ++++++++++++
 tb/tb_ifm_chunk_ring_buffer.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ifm_chunk_ring_buffer_pkg.sv
// rtl/ifm_chunk_ring_buffer_pkg.sv - sizing constants, beat types and popcount for the IFM chunk ring buffer
package ifm_chunk_pkg;
    localparam int BUS_SIZE         = 32;
    localparam int CHUNK_SIZE       = 128;
    localparam int BANK_NUM         = 4;
    localparam int COMPUTE_UNIT_NUM = 8;
    localparam int PREFIX_SUM_SIZE  = 8;

    localparam int WR_BEAT_NUM  = CHUNK_SIZE / BUS_SIZE;
    localparam int SM_SLICE_NUM = CHUNK_SIZE / PREFIX_SUM_SIZE;
    localparam int ADDR_W       = $clog2(CHUNK_SIZE) + 1;
    localparam int BANK_W       = $clog2(BANK_NUM);
    localparam int BEAT_W       = (WR_BEAT_NUM > 1) ? $clog2(WR_BEAT_NUM) : 1;
    localparam int PC_W         = $clog2(BUS_SIZE) + 1;
    localparam int SM_ADDR_W    = $clog2(SM_SLICE_NUM);
    localparam int FULL_W       = $clog2(BANK_NUM) + 1;

    typedef logic [BUS_SIZE-1:0]      sparsemap_t;
    typedef logic [BUS_SIZE-1:0][7:0] chunk_data_t;

    function automatic logic [PC_W-1:0] popcount(input sparsemap_t sm);
        logic [PC_W-1:0] n;
        n = '0;
        for (int i = 0; i < BUS_SIZE; i++) begin
            n = n + PC_W'(sm[i]);
        end
        return n;
    endfunction
endpackage

// File: rtl/ifm_chunk_ring_buffer_if.sv
// rtl/ifm_chunk_ring_buffer_if.sv - write-beat stream from the IFM DMA into the chunk ring buffer
interface ifm_chunk_ring_buffer_if;
    import ifm_chunk_pkg::*;

    logic        wr_valid_i;
    logic        wr_ready_o;
    sparsemap_t  wr_sparsemap_i;
    chunk_data_t wr_nonzero_data_i;

    modport master (output wr_valid_i, output wr_sparsemap_i, output wr_nonzero_data_i,
                    input  wr_ready_o);
    modport slave  (input  wr_valid_i, input  wr_sparsemap_i, input  wr_nonzero_data_i,
                    output wr_ready_o);
endinterface

// File: rtl/ifm_chunk_ring_buffer_bank.sv
// rtl/ifm_chunk_ring_buffer_bank.sv - one chunk store: sparsemap, compacted nonzero bytes, nz_count and valid flag
module ifm_chunk_bank
    import ifm_chunk_pkg::*;
(
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          wr_en_i,
    input  logic                          wr_last_i,
    input  logic [BEAT_W-1:0]             wr_beat_i,
    input  logic [ADDR_W-2:0]             wr_base_i,
    input  logic [PC_W-1:0]               wr_pc_i,
    input  logic [ADDR_W-1:0]             wr_nz_count_i,
    input  sparsemap_t                    wr_sparsemap_i,
    input  chunk_data_t                   wr_data_i,
    input  logic                          clr_i,
    output logic                          valid_o,
    output logic [ADDR_W-1:0]             nz_count_o,
    output logic [CHUNK_SIZE-1:0]         sparsemap_o,
    output logic [CHUNK_SIZE-1:0][7:0]    data_o
);
    logic                       valid_q;
    logic [ADDR_W-1:0]          nz_count_q;
    logic [CHUNK_SIZE-1:0]      sm_q;
    logic [CHUNK_SIZE-1:0][7:0] data_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q    <= 1'b0;
            nz_count_q <= '0;
        end else if (wr_en_i && wr_last_i) begin
            valid_q    <= 1'b1;
            nz_count_q <= wr_nz_count_i;
        end else if (clr_i) begin
            valid_q    <= 1'b0;
        end
    end

    // Byte n (1-based) lives at data_q[n-1]; a beat appends its pc bytes after wr_base_i.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            sm_q[int'(wr_beat_i)*BUS_SIZE +: BUS_SIZE] <= wr_sparsemap_i;
            for (int k = 0; k < BUS_SIZE; k++) begin
                if (PC_W'(k) < wr_pc_i) begin
                    data_q[wr_base_i + (ADDR_W-1)'(k)] <= wr_data_i[k];
                end
            end
        end
    end

    assign valid_o     = valid_q;
    assign nz_count_o  = nz_count_q;
    assign sparsemap_o = sm_q;
    assign data_o      = data_q;
endmodule

// File: rtl/ifm_chunk_ring_buffer.sv
// rtl/ifm_chunk_ring_buffer.sv - N-bank ring of sparse IFM chunks between the IFM DMA and the compute units
module ifm_chunk_ring_buffer
    import ifm_chunk_pkg::*;
(
    input  logic                                              clk_i,
    input  logic                                              rst_i,
    ifm_chunk_ring_buffer_if.slave                            wr,
    output logic                                              wr_chunk_done_o,
    output logic                                              rd_valid_o,
    output logic [BANK_W-1:0]                                 rd_bank_o,
    output logic [ADDR_W-1:0]                                 rd_nz_count_o,
    input  logic                                              rd_done_i,
    input  logic [COMPUTE_UNIT_NUM-1:0][ADDR_W-1:0]           rd_addr_i,
    output logic [COMPUTE_UNIT_NUM-1:0][7:0]                  rd_data_o,
    input  logic [COMPUTE_UNIT_NUM-1:0][SM_ADDR_W-1:0]        rd_sparsemap_addr_i,
    output logic [COMPUTE_UNIT_NUM-1:0][PREFIX_SUM_SIZE-1:0]  rd_sparsemap_o
);
    logic [BANK_W-1:0] wr_ptr_q,   wr_ptr_d;
    logic [BANK_W-1:0] rd_ptr_q,   rd_ptr_d;
    logic [FULL_W-1:0] full_cnt_q, full_cnt_d;
    logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [ADDR_W-1:0] nz_ptr_q,   nz_ptr_d;
    logic              done_q;
    logic [COMPUTE_UNIT_NUM-1:0][7:0]                 rd_data_q,  rd_data_d;
    logic [COMPUTE_UNIT_NUM-1:0][PREFIX_SUM_SIZE-1:0] rd_sm_q,    rd_sm_d;

    logic              accept, last_beat, release_c;
    logic [PC_W-1:0]   pc;
    logic [ADDR_W-1:0] nz_end;

    logic                       bank_valid [BANK_NUM];
    logic [ADDR_W-1:0]          bank_nz    [BANK_NUM];
    logic [CHUNK_SIZE-1:0]      bank_sm    [BANK_NUM];
    logic [CHUNK_SIZE-1:0][7:0] bank_data  [BANK_NUM];

    assign pc            = popcount(wr.wr_sparsemap_i);
    assign nz_end        = nz_ptr_q + ADDR_W'(pc);
    assign wr.wr_ready_o = rst_i && (full_cnt_q != FULL_W'(BANK_NUM));
    assign accept        = wr.wr_valid_i && wr.wr_ready_o;
    assign last_beat     = accept && (beat_cnt_q == BEAT_W'(WR_BEAT_NUM - 1));
    assign release_c     = rd_done_i && rd_valid_o;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        beat_cnt_d = beat_cnt_q;
        nz_ptr_d   = nz_ptr_q;
        full_cnt_d = full_cnt_q + FULL_W'(last_beat) - FULL_W'(release_c);
        if (accept) begin
            beat_cnt_d = beat_cnt_q + 1'b1;
            nz_ptr_d   = nz_end;
        end
        if (last_beat) begin
            wr_ptr_d   = wr_ptr_q + 1'b1;
            beat_cnt_d = '0;
            nz_ptr_d   = '0;
        end
        if (release_c) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            full_cnt_q <= '0;
            beat_cnt_q <= '0;
            nz_ptr_q   <= '0;
            done_q     <= 1'b0;
            rd_data_q  <= '0;
            rd_sm_q    <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            full_cnt_q <= full_cnt_d;
            beat_cnt_q <= beat_cnt_d;
            nz_ptr_q   <= nz_ptr_d;
            done_q     <= last_beat;
            rd_data_q  <= rd_data_d;
            rd_sm_q    <= rd_sm_d;
        end
    end

    for (genvar b = 0; b < BANK_NUM; b++) begin : g_bank
        ifm_chunk_bank u_bank (
            .clk_i          (clk_i),
            .rst_i          (rst_i),
            .wr_en_i        (accept && (wr_ptr_q == BANK_W'(b))),
            .wr_last_i      (last_beat),
            .wr_beat_i      (beat_cnt_q),
            .wr_base_i      (nz_ptr_q[ADDR_W-2:0]),
            .wr_pc_i        (pc),
            .wr_nz_count_i  (nz_end),
            .wr_sparsemap_i (wr.wr_sparsemap_i),
            .wr_data_i      (wr.wr_nonzero_data_i),
            .clr_i          (release_c && (rd_ptr_q == BANK_W'(b))),
            .valid_o        (bank_valid[b]),
            .nz_count_o     (bank_nz[b]),
            .sparsemap_o    (bank_sm[b]),
            .data_o         (bank_data[b])
        );
    end

    // addr-1 has its top bit clear exactly when 1 <= addr <= CHUNK_SIZE.
    for (genvar c = 0; c < COMPUTE_UNIT_NUM; c++) begin : g_cu
        logic [ADDR_W-1:0] addr_m1;
        assign addr_m1 = rd_addr_i[c] - 1'b1;

        always_comb begin
            rd_data_d[c] = '0;
            rd_sm_d[c]   = '0;
            if (bank_valid[rd_ptr_q]) begin
                rd_sm_d[c] = bank_sm[rd_ptr_q][int'(rd_sparsemap_addr_i[c])*PREFIX_SUM_SIZE +: PREFIX_SUM_SIZE];
                if (!addr_m1[ADDR_W-1] && (rd_addr_i[c] <= bank_nz[rd_ptr_q])) begin
                    rd_data_d[c] = bank_data[rd_ptr_q][addr_m1[ADDR_W-2:0]];
                end
            end
        end
    end

    assign wr_chunk_done_o = done_q;
    assign rd_valid_o      = (full_cnt_q != '0);
    assign rd_bank_o       = rd_ptr_q;
    assign rd_nz_count_o   = bank_nz[rd_ptr_q];
    assign rd_data_o       = rd_data_q;
    assign rd_sparsemap_o  = rd_sm_q;
endmodule

// File: tb/tb_ifm_chunk_ring_buffer.sv
// tb/tb_ifm_chunk_ring_buffer.sv - directed scoreboard bench for ifm_chunk_ring_buffer
module tb_ifm_chunk_ring_buffer;
    import ifm_chunk_pkg::*;

    logic clk;
    logic rst;
    logic done_o, rd_valid, rd_done;
    logic [BANK_W-1:0] rd_bank;
    logic [ADDR_W-1:0] rd_nz;
    logic [COMPUTE_UNIT_NUM-1:0][ADDR_W-1:0]          rd_addr;
    logic [COMPUTE_UNIT_NUM-1:0][7:0]                 rd_data;
    logic [COMPUTE_UNIT_NUM-1:0][SM_ADDR_W-1:0]       rd_sm_addr;
    logic [COMPUTE_UNIT_NUM-1:0][PREFIX_SUM_SIZE-1:0] rd_sm;

    ifm_chunk_ring_buffer_if wr_if ();

    ifm_chunk_ring_buffer dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .wr                  (wr_if),
        .wr_chunk_done_o     (done_o),
        .rd_valid_o          (rd_valid),
        .rd_bank_o           (rd_bank),
        .rd_nz_count_o       (rd_nz),
        .rd_done_i           (rd_done),
        .rd_addr_i           (rd_addr),
        .rd_data_o           (rd_data),
        .rd_sparsemap_addr_i (rd_sm_addr),
        .rd_sparsemap_o      (rd_sm)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int                    nz;
        logic [7:0]            d [CHUNK_SIZE+1];
        logic [CHUNK_SIZE-1:0] sm;
    } chunk_t;

    chunk_t     chq[$];
    chunk_t     cur;
    int         cur_beat;
    int         exp_bank;
    logic [7:0] exp_data_q[$];
    logic [7:0] exp_sm_q[$];
    int         checks;
    int         failures;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic new_chunk();
        cur.nz = 0;
        cur.sm = '0;
        for (int i = 0; i <= CHUNK_SIZE; i++) cur.d[i] = 8'h00;
        cur_beat = 0;
    endtask

    task automatic write_beat(input logic [31:0] sm, input logic [7:0] dbase);
        int n;
        int pc;
        bit last;
        wr_if.wr_valid_i     = 1'b1;
        wr_if.wr_sparsemap_i = sm;
        for (int k = 0; k < BUS_SIZE; k++) wr_if.wr_nonzero_data_i[k] = dbase + 8'(k);
        n = 0;
        while (wr_if.wr_ready_o !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) chk("wr_ready_timeout", 32'(wr_if.wr_ready_o), 32'd1);
        @(posedge clk);
        #1;
        wr_if.wr_valid_i = 1'b0;
        pc = $countones(sm);
        cur.sm[cur_beat*BUS_SIZE +: BUS_SIZE] = sm;
        for (int k = 0; k < pc; k++) cur.d[cur.nz+1+k] = dbase + 8'(k);
        cur.nz += pc;
        last = (cur_beat == WR_BEAT_NUM - 1);
        chk("chunk_done", 32'(done_o), 32'(last));
        cur_beat++;
        if (last) begin
            chq.push_back(cur);
            new_chunk();
        end
    endtask

    task automatic write_chunk(input logic [31:0] s0, s1, s2, s3, input logic [7:0] dbase);
        write_beat(s0, dbase);
        write_beat(s1, dbase);
        write_beat(s2, dbase);
        write_beat(s3, dbase);
    endtask

    task automatic check_head(input string tag);
        chk({tag, "_valid"}, 32'(rd_valid), 32'(chq.size() != 0));
        chk({tag, "_bank"}, 32'(rd_bank), 32'(exp_bank));
        if (chq.size() != 0) chk({tag, "_nz"}, 32'(rd_nz), 32'(chq[0].nz));
    endtask

    task automatic release_head();
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
        if (chq.size() != 0) begin
            chq.delete(0);
            exp_bank = (exp_bank + 1) % BANK_NUM;
        end
    endtask

    task automatic read_check(input int a0, input int step, input int s0);
        int a;
        int s;
        for (int c = 0; c < COMPUTE_UNIT_NUM; c++) begin
            a = (a0 + c * step) & ((1 << ADDR_W) - 1);
            s = (s0 + c) & (SM_SLICE_NUM - 1);
            rd_addr[c]    = ADDR_W'(a);
            rd_sm_addr[c] = SM_ADDR_W'(s);
            if (chq.size() != 0 && a >= 1 && a <= chq[0].nz) exp_data_q.push_back(chq[0].d[a]);
            else exp_data_q.push_back(8'h00);
            if (chq.size() != 0) exp_sm_q.push_back(chq[0].sm[s*PREFIX_SUM_SIZE +: PREFIX_SUM_SIZE]);
            else exp_sm_q.push_back(8'h00);
        end
        tick();
        for (int c = 0; c < COMPUTE_UNIT_NUM; c++) begin
            chk($sformatf("rd_data[%0d]", c), 32'(rd_data[c]), 32'(exp_data_q.pop_front()));
            chk($sformatf("rd_sm[%0d]", c), 32'(rd_sm[c]), 32'(exp_sm_q.pop_front()));
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        exp_bank = 0;
        rst      = 1'b0;
        rd_done  = 1'b0;
        rd_addr  = '0;
        rd_sm_addr = '0;
        wr_if.wr_valid_i        = 1'b0;
        wr_if.wr_sparsemap_i    = '0;
        wr_if.wr_nonzero_data_i = '0;
        new_chunk();
        #1;
        chk("rst_ready", 32'(wr_if.wr_ready_o), 32'd0);
        chk("rst_valid", 32'(rd_valid), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        chk("post_rst_ready", 32'(wr_if.wr_ready_o), 32'd1);
        check_head("post_rst");

        // Fill and zero padding
        write_chunk(32'h0000_000F, 32'h0000_000F, 32'h0000_000F, 32'h0000_000F, 8'd1);
        check_head("fill");
        chk("fill_nz16", 32'(rd_nz), 32'd16);
        read_check(5, 12, 0);
        chk("addr5", 32'(rd_data[0]), 32'h01);
        chk("addr17", 32'(rd_data[1]), 32'h00);
        read_check(0, 0, 0);
        chk("sm_slice0", 32'(rd_sm[0]), 32'h0F);
        release_head();
        check_head("empty");
        release_head();
        check_head("done_at_empty");

        // Full ring with wrap and ordering
        write_chunk(32'h0, 32'h0, 32'h0, 32'h0, 8'h10);
        write_chunk(32'hFF, 32'hFF, 32'hFF, 32'hFF, 8'h20);
        write_chunk(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'h40);
        write_chunk(32'h7F, 32'h0, 32'h0, 32'h0, 8'h80);
        chk("full_ready", 32'(wr_if.wr_ready_o), 32'd0);
        check_head("full_head");
        wr_if.wr_valid_i     = 1'b1;
        wr_if.wr_sparsemap_i = 32'hFF;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_ready", 32'(wr_if.wr_ready_o), 32'd0);
            chk("stall_done", 32'(done_o), 32'd0);
        end
        wr_if.wr_valid_i = 1'b0;
        release_head();
        chk("ready_after_release", 32'(wr_if.wr_ready_o), 32'd1);
        check_head("wrap_b");
        read_check(1, 5, 3);
        write_chunk(32'h7, 32'h7, 32'h7, 32'h7, 8'hA0);
        chk("refull_ready", 32'(wr_if.wr_ready_o), 32'd0);
        release_head();
        check_head("wrap_c");
        read_check(97, 4, 9);
        release_head();
        check_head("wrap_d");
        read_check(6, 1, 0);
        write_chunk(32'h1, 32'h3, 32'h5, 32'h9, 8'hC0);
        release_head();
        check_head("wrap_e");

        // Commit and release in the same cycle with two chunks held
        write_beat(32'hF0, 8'h30);
        write_beat(32'h0, 8'h30);
        write_beat(32'h3, 8'h30);
        rd_done = 1'b1;
        write_beat(32'h1, 8'h30);
        rd_done = 1'b0;
        chq.delete(0);
        exp_bank = (exp_bank + 1) % BANK_NUM;
        check_head("simul");
        release_head();
        check_head("simul_r1");
        release_head();
        check_head("simul_r2");

        // Reset in the middle of a chunk
        write_chunk(32'h3, 32'h3, 32'h3, 32'h3, 8'h55);
        check_head("pre_rst");
        read_check(1, 1, 0);
        write_beat(32'hFF, 8'h66);
        write_beat(32'hFF, 8'h66);
        #1;
        rst = 1'b0;
        #1;
        chk("arst_valid", 32'(rd_valid), 32'd0);
        chk("arst_bank", 32'(rd_bank), 32'd0);
        chk("arst_nz", 32'(rd_nz), 32'd0);
        chk("arst_ready", 32'(wr_if.wr_ready_o), 32'd0);
        chk("arst_data", 32'(rd_data), 32'd0);
        chk("arst_data_hi", 32'(rd_data >> 32), 32'd0);
        chk("arst_sm", 32'(rd_sm), 32'd0);
        chq.delete();
        exp_bank = 0;
        new_chunk();
        @(negedge clk);
        rst = 1'b1;
        tick();
        write_chunk(32'h3, 32'h1, 32'h0, 32'h8000_0000, 8'h77);
        check_head("post_arst");
        chk("post_arst_nz4", 32'(rd_nz), 32'd4);
        read_check(1, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
